median_sched: RTL and testbench

Raster-scan 3x3 median filter scheduler. It accepts a pixel stream, keeps two line buffers and a 3x3 window, and runs one job on the shared 9-input median sort core per fully-populated window. For each job it streams the 9 window pixels into the core, waits for the core's result strobe, then presents the filtered pixel on a valid/ready output. It sits between the video input path and the median core.

---
 rtl/median_sched.sv | 165 ++++++++++++++++
 tb/tb_median_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_sched.sv
// Raster-scan 3x3 median filter scheduler: line buffers, sliding window and job sequencing for a shared median core.
// Optional WAIT watchdog with sticky error flag is enabled by defining MEDIAN_SCHED_TIMEOUT_EN.
module median_sched #(
    parameter int W      = 8,
    parameter int LINE_W = 640,
    parameter int XW     = $clog2(LINE_W)
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [W-1:0] PIX_I,
    input  logic         PIX_VAL_I,
    output logic         PIX_RDY_O,
    input  logic         SOF_I,
    output logic [W-1:0] MED_DI,
    output logic         MED_DSI,
    input  logic [W-1:0] MED_DO,
    input  logic         MED_DSO,
    output logic [W-1:0] PIX_O,
    output logic         PIX_VAL_O,
    input  logic         PIX_RDY_I,
    output logic         BUSY_O,
    output logic         ERR_O
);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, OUT} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [1:0]    ry;
    logic [3:0]    n;
    logic [3:0]    n_next;

    logic [W-1:0]  lb0 [LINE_W];
    logic [W-1:0]  lb1 [LINE_W];
    logic [W-1:0]  win [9];
    logic [W-1:0]  win_next [9];

    logic          accept;
    logic          trigger;
    logic          last_col;
    logic [XW-1:0] col;
    logic [W-1:0]  lb0_rd;
    logic [W-1:0]  lb1_rd;

`ifdef MEDIAN_SCHED_TIMEOUT_EN
    logic [7:0]    wdog;
    logic          err;
`endif

    // A SOF pixel is always column 0, regardless of where the previous frame stopped.
    assign accept   = PIX_VAL_I && PIX_RDY_O;
    assign col      = SOF_I ? '0 : x;
    assign last_col = (col == XW'(LINE_W - 1));
    assign trigger  = accept && (ry == 2'd2) && (col >= XW'(2));
    assign lb0_rd   = lb0[col];
    assign lb1_rd   = lb1[col];
    assign n_next   = n + 4'd1;

    assign PIX_RDY_O = (state == IDLE);
    assign BUSY_O    = (state != IDLE);

`ifdef MEDIAN_SCHED_TIMEOUT_EN
    assign ERR_O = err;
`else
    assign ERR_O = 1'b0;
`endif

    // Row-major window, index 0 top-left; the incoming column lands on the right.
    always_comb begin
        win_next[0] = win[1];
        win_next[1] = win[2];
        win_next[2] = lb1_rd;
        win_next[3] = win[4];
        win_next[4] = win[5];
        win_next[5] = lb0_rd;
        win_next[6] = win[7];
        win_next[7] = win[8];
        win_next[8] = PIX_I;
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= PIX_I;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            x         <= '0;
            ry        <= '0;
            n         <= '0;
            MED_DSI   <= 1'b0;
            MED_DI    <= '0;
            PIX_O     <= '0;
            PIX_VAL_O <= 1'b0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
            wdog      <= '0;
            err       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                for (int i = 0; i < 9; i++) win[i] <= win_next[i];
                x <= last_col ? '0 : col + 1'b1;
                if (SOF_I) begin
                    ry <= 2'd0;
                end else if (last_col && (ry != 2'd2)) begin
                    ry <= ry + 2'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= FEED;
                        n       <= 4'd0;
                        MED_DSI <= 1'b1;
                        MED_DI  <= win_next[0];
                    end
                end
                FEED: begin
                    if (n == 4'd8) begin
                        state   <= WAIT;
                        MED_DSI <= 1'b0;
                        MED_DI  <= '0;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
                        wdog    <= '0;
`endif
                    end else begin
                        n      <= n_next;
                        MED_DI <= win[n_next];
                    end
                end
                WAIT: begin
                    if (MED_DSO) begin
                        PIX_O     <= MED_DO;
                        PIX_VAL_O <= 1'b1;
                        state     <= OUT;
                    end
`ifdef MEDIAN_SCHED_TIMEOUT_EN
                    // Stalled core: pass the unfiltered centre through and flag it.
                    else if (wdog == 8'hFF) begin
                        PIX_O     <= win[4];
                        PIX_VAL_O <= 1'b1;
                        state     <= OUT;
                        err       <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end
                OUT: begin
                    if (PIX_RDY_I) begin
                        PIX_VAL_O <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_sched.sv
// Self-checking bench for median_sched with LINE_W=4: scoreboarded windows/medians and a behavioural median core.
`timescale 1ns/1ps
module tb_median_sched;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int XW = $clog2(LW);

    logic         CLK  = 1'b0;
    logic         nRST = 1'b1;
    logic [W-1:0] PIX_I;
    logic         PIX_VAL_I;
    logic         PIX_RDY_O;
    logic         SOF_I;
    logic [W-1:0] MED_DI;
    logic         MED_DSI;
    logic [W-1:0] MED_DO;
    logic         MED_DSO;
    logic [W-1:0] PIX_O;
    logic         PIX_VAL_O;
    logic         PIX_RDY_I;
    logic         BUSY_O;
    logic         ERR_O;

    median_sched #(.W(W), .LINE_W(LW), .XW(XW)) dut (
        .CLK(CLK), .nRST(nRST),
        .PIX_I(PIX_I), .PIX_VAL_I(PIX_VAL_I), .PIX_RDY_O(PIX_RDY_O), .SOF_I(SOF_I),
        .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(MED_DO), .MED_DSO(MED_DSO),
        .PIX_O(PIX_O), .PIX_VAL_O(PIX_VAL_O), .PIX_RDY_I(PIX_RDY_I),
        .BUSY_O(BUSY_O), .ERR_O(ERR_O)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int win_q[$];
    int img[32][LW];
    int mrow = 0, mcol = 0;
    int dsi_cycles = 0, rdy_low = 0, outputs = 0;
    bit core_stall = 1'b0;
    int last_center = 0;

    int cnt = 0, run = 0, lat = -1;
    int got[9];

    int b, held, dsi_save, rdy_save, m;
    bit stable;

    function automatic int med9(input int v[9]);
        int a[9];
        int t;
        a = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural median core plus downstream scoreboard, evaluated once per cycle on the falling edge.
    task automatic monitor();
        int           mv;
        logic [31:0]  em;
        if (!nRST) begin
            cnt = 0; run = 0; lat = -1; MED_DSO = 1'b0;
            return;
        end
        vectors++;
        assert (!(PIX_VAL_O && PIX_RDY_O)) else begin
            miscompares++;
            $error("FAIL val_rdy_excl: PIX_VAL_O=%b PIX_RDY_O=%b expected not both 1", PIX_VAL_O, PIX_RDY_O);
        end
        if (!PIX_RDY_O) rdy_low++;
        if (MED_DSO) begin
            MED_DSO = 1'b0;
            vectors++;
            assert (PIX_VAL_O === 1'b1) else begin
                miscompares++;
                $error("FAIL dso_to_val: PIX_VAL_O=%b expected 1", PIX_VAL_O);
            end
        end
        if (MED_DSI) begin
            dsi_cycles++;
            run++;
            mv = (win_q.size() > 0) ? win_q.pop_front() : -1;
            em = mv;
            vectors++;
            assert (mv >= 0 && MED_DI === em[W-1:0]) else begin
                miscompares++;
                $error("FAIL med_di: observed %0d expected %0d", MED_DI, mv);
            end
            got[cnt] = int'(MED_DI);
            cnt++;
            if (cnt == 9) begin
                cnt = 0;
                lat = core_stall ? -1 : 3;
            end
        end else if (run != 0) begin
            vectors++;
            assert (run == 9 && MED_DI === '0) else begin
                miscompares++;
                $error("FAIL feed_len: observed %0d strobes (MED_DI=%0d) expected 9 (MED_DI=0)", run, MED_DI);
            end
            run = 0;
        end
        if (lat > 0) begin
            lat--;
        end else if (lat == 0) begin
            mv = med9(got);
            em = mv;
            MED_DO  = em[W-1:0];
            MED_DSO = 1'b1;
            lat = -1;
        end
        if (PIX_VAL_O && PIX_RDY_I) begin
            outputs++;
            mv = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            em = mv;
            vectors++;
            assert (mv >= 0 && PIX_O === em[W-1:0]) else begin
                miscompares++;
                $error("FAIL pix_out: observed %0d expected %0d", PIX_O, mv);
            end
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(negedge CLK);
            monitor();
            @(posedge CLK);
            #1;
        end
    endtask

    // Drives one pixel and records the window/median the reference image predicts for it.
    task automatic send_pixel(input int pix, input bit sof);
        int          wv[9];
        int          budget;
        logic [31:0] pv;
        budget = 0;
        while (!PIX_RDY_O && budget < 500) begin
            step(1);
            budget++;
        end
        check_output("rdy_wait", PIX_RDY_O, 1);
        if (sof) begin
            mrow = 0;
            mcol = 0;
        end
        img[mrow][mcol] = pix;
        if (mrow >= 2 && mcol >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    wv[r*3+c] = img[mrow-2+r][mcol-2+c];
                    win_q.push_back(wv[r*3+c]);
                end
            exp_q.push_back(med9(wv));
            last_center = wv[4];
        end
        mcol++;
        if (mcol == LW) begin
            mcol = 0;
            mrow++;
        end
        pv        = pix;
        PIX_I     = pv[W-1:0];
        SOF_I     = sof;
        PIX_VAL_I = 1'b1;
        step(1);
        PIX_VAL_I = 1'b0;
        SOF_I     = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int bd;
        bd = 0;
        while ((exp_q.size() != 0 || !PIX_RDY_O) && bd < 1000) begin
            step(1);
            bd++;
        end
        check_output({tag, "_drain"}, (bd < 1000), 1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        PIX_I = '0; PIX_VAL_I = 1'b0; SOF_I = 1'b0;
        MED_DO = '0; MED_DSO = 1'b0; PIX_RDY_I = 1'b1;
        #2;
        nRST = 1'b0;
        step(3);
        check_output("rst_rdy",  PIX_RDY_O, 1);
        check_output("rst_dsi",  MED_DSI,   0);
        check_output("rst_di",   MED_DI,    0);
        check_output("rst_pix",  PIX_O,     0);
        check_output("rst_val",  PIX_VAL_O, 0);
        check_output("rst_busy", BUSY_O,    0);
        check_output("rst_err",  ERR_O,     0);
        nRST = 1'b1;
        step(2);

        // Frame 1: rows 1..4, 5..8 give no jobs.
        send_pixel(1, 1'b1);
        for (int p = 2; p <= 8; p++) send_pixel(p, 1'b0);
        step(3);
        check_output("rows01_no_dsi",  dsi_cycles, 0);
        check_output("rows01_rdy_high", rdy_low,    0);

        for (int p = 9; p <= 12; p++) send_pixel(p, 1'b0);
        wait_drain("row2");
        check_output("row2_outputs",  outputs,    2);
        check_output("row2_dsi_cnt",  dsi_cycles, 18);

        // Backpressure on the first job of the fourth row.
        send_pixel(13, 1'b0);
        send_pixel(14, 1'b0);
        PIX_RDY_I = 1'b0;
        send_pixel(15, 1'b0);
        b = 0;
        while (!PIX_VAL_O && b < 200) begin
            step(1);
            b++;
        end
        check_output("bp_valid", PIX_VAL_O, 1);
        held   = int'(PIX_O);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (int'(PIX_O) != held || PIX_RDY_O !== 1'b0 || PIX_VAL_O !== 1'b1) stable = 1'b0;
        end
        check_output("bp_stable", stable, 1);
        check_output("bp_outputs_held", outputs, 2);
        PIX_RDY_I = 1'b1;
        step(1);
        check_output("hs_val_low", PIX_VAL_O, 0);
        check_output("hs_rdy_high", PIX_RDY_O, 1);
        send_pixel(16, 1'b0);
        wait_drain("row3");
        check_output("row3_outputs", outputs, 4);

        // Mid-line SOF starts frame 2 with random content.
        send_pixel($urandom_range(255), 1'b0);
        send_pixel($urandom_range(255), 1'b0);
        dsi_save = dsi_cycles;
        rdy_save = rdy_low;
        for (int p = 0; p < 8; p++) send_pixel($urandom_range(255), (p == 0));
        step(3);
        check_output("f2_rows01_no_dsi", dsi_cycles, dsi_save);
        check_output("f2_rows01_rdy",    rdy_low,    rdy_save);
        check_output("f2_rows01_outs",   outputs,    4);
        for (int p = 0; p < 4; p++) send_pixel($urandom_range(255), 1'b0);
        wait_drain("f2_row2");
        check_output("f2_row2_outputs", outputs, 6);
        check_output("f2_dsi_cnt", dsi_cycles, dsi_save + 18);

`ifdef MEDIAN_SCHED_TIMEOUT_EN
        send_pixel($urandom_range(255), 1'b0);
        send_pixel($urandom_range(255), 1'b0);
        core_stall = 1'b1;
        send_pixel($urandom_range(255), 1'b0);
        m = exp_q.pop_back();
        exp_q.push_back(last_center);
        b = 0;
        while (!PIX_VAL_O && b < 400) begin
            step(1);
            b++;
        end
        check_output("timeout_val", PIX_VAL_O, 1);
        check_output("timeout_len", (b >= 255 && b <= 280), 1);
        check_output("timeout_err", ERR_O, 1);
        wait_drain("timeout");
        core_stall = 1'b0;
        send_pixel($urandom_range(255), 1'b0);
        wait_drain("after_timeout");
        check_output("err_sticky", ERR_O, 1);
`else
        check_output("err_tied", ERR_O, 0);
`endif
        check_output("exp_q_empty", exp_q.size(), 0);
        check_output("win_q_empty", win_q.size(), 0);

        // Reset in the middle of FEED aborts the job.
        send_pixel($urandom_range(255), 1'b1);
        for (int p = 1; p < 11; p++) send_pixel($urandom_range(255), 1'b0);
        step(2);
        check_output("feed_active", MED_DSI, 1);
        check_output("feed_busy",   BUSY_O,  1);
        held = outputs;
        nRST = 1'b0;
        step(1);
        check_output("abort_dsi",  MED_DSI,   0);
        check_output("abort_val",  PIX_VAL_O, 0);
        check_output("abort_rdy",  PIX_RDY_O, 1);
        check_output("abort_busy", BUSY_O,    0);
        exp_q.delete();
        win_q.delete();
        nRST = 1'b1;
        step(20);
        check_output("post_abort_val",  PIX_VAL_O, 0);
        check_output("post_abort_dsi",  MED_DSI,   0);
        check_output("post_abort_outs", outputs,   held);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
